// File: rtl/gf163_divider_if.sv
// Request/result bundle of the GF(2^163) divider: operands and start in,
// busy/done/quotient/error out.
interface gf163_divider_if #(
  parameter int M = 163
);
  logic         start;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         busy;
  logic         done;
  logic [M-1:0] c;
  logic         err;

  modport master (output start, a, b, input busy, done, c, err);
  modport slave  (input start, a, b, output busy, done, c, err);
endinterface

// File: rtl/gf163_divider.sv
// Sequential GF(2^163) divider c = a * b^-1 mod f(x) (binary extended Euclid, one step per cycle).
// Optional divide-by-zero detection is enabled by defining GF163_DIV_ZCHK_EN.
//
// state | meaning
// IDLE  | waiting for start; c holds the last quotient
// RUN   | one Euclid step per cycle until u==1, v==1 or the iteration cap
// DONE  | one-cycle done pulse with c/err valid, then back to IDLE
module gf163_divider #(
  parameter int           M    = 163,
  parameter logic [M-1:0] POLY = {{(M-8){1'b0}}, 8'hC9}
) (
  input  logic           clk,
  input  logic           rst_n,
  gf163_divider_if.slave bus
);
  localparam int         MAXCYC = 4 * M;
  localparam int         CW     = $clog2(MAXCYC + 1);
  localparam int         DW     = $clog2(M + 1);
  localparam logic [M:0] ONE    = {{M{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [M:0]    u_q, u_d;
  logic [M:0]    v_q, v_d;
  logic [M-1:0]  g1_q, g1_d;
  logic [M-1:0]  g2_q, g2_d;
  logic [M-1:0]  c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef GF163_DIV_ZCHK_EN
  logic          err_q, err_d;
`endif

  // Degree of a polynomial: index of its leading one.
  function automatic logic [DW-1:0] deg(input logic [M:0] x);
    deg = '0;
    for (int i = 0; i <= M; i++) begin
      if (x[i]) deg = DW'(i);
    end
  endfunction

  // g / x mod f: add f first when g is odd so the shift is exact.
  function automatic logic [M-1:0] div_x(input logic [M-1:0] g);
    logic [M:0] t;
    t = g[0] ? ({1'b0, g} ^ {1'b1, POLY}) : {1'b0, g};
    div_x = t[M:1];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      g1_q    <= '0;
      g2_q    <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
`ifdef GF163_DIV_ZCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
`ifdef GF163_DIV_ZCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
`ifdef GF163_DIV_ZCHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          u_d   = {1'b0, bus.b};
          v_d   = {1'b1, POLY};
          g1_d  = bus.a;
          g2_d  = '0;
          cnt_d = '0;
`ifdef GF163_DIV_ZCHK_EN
          err_d = (bus.b == '0);
          if (bus.b == '0) begin
            c_d     = '0;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        // Termination tests come before any update, so u==v==1 returns g1.
        if (u_q == ONE) begin
          c_d     = g1_q;
          state_d = DONE;
        end else if (v_q == ONE) begin
          c_d     = g2_q;
          state_d = DONE;
        end else if (cnt_q == CW'(MAXCYC)) begin
          c_d     = '0;
          state_d = DONE;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          g1_d = div_x(g1_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          g2_d = div_x(g2_q);
        end else if (deg(u_q) > deg(v_q)) begin
          u_d  = u_q ^ v_q;
          g1_d = g1_q ^ g2_q;
        end else begin
          v_d  = v_q ^ u_q;
          g2_d = g2_q ^ g1_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.c    = c_q;
`ifdef GF163_DIV_ZCHK_EN
  assign bus.err  = err_q;
`else
  assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_gf163_divider.sv
// Directed and model-checked bench for gf163_divider: exact latencies, known quotients,
// ignored starts, zero divisor, back-to-back requests and reset abort.
module tb_gf163_divider;
  localparam int           M      = 163;
  localparam int           MAXCYC = 4 * M;
  localparam int           LIMIT  = MAXCYC + 40;
  localparam logic [M-1:0] POLY   = 163'hC9;
  localparam logic [M-1:0] ONE    = 163'd1;
  localparam logic [M-1:0] X162   = {1'b1, 162'b0};
  localparam logic [M-1:0] INV_X  = {1'b1, 155'b0, 7'b1100100};

  typedef struct {
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] c;
    int           lat;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  gf163_divider_if #(.M(M)) bus ();

  gf163_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference multiply mod f(x), shift-and-add with per-step reduction.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] r;
    logic [M-1:0] t;
    r = '0;
    t = x;
    for (int i = 0; i < M; i++) begin
      if (y[i]) r = r ^ t;
      t = t[M-1] ? ((t << 1) ^ POLY) : (t << 1);
    end
    return r;
  endfunction

  function automatic logic [M-1:0] rand163();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (w[M-1:0] == '0) w[0] = 1'b1;
    return w[M-1:0];
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the done cycle (or after LIMIT).
  task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b,
                        output logic [M-1:0] c, output logic err, output int lat);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    lat       = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
    end while (!bus.done && lat < LIMIT);
    c   = bus.c;
    err = bus.err;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.c !== '0) begin n_bad++; $display("FAIL reset_c: got %h want 0", bus.c); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_directed();
    vec_t         v [8];
    logic [M-1:0] c;
    logic         e;
    int           lat;
    v[0] = '{a: ONE,       b: ONE,       c: ONE,      lat: 2};
    v[1] = '{a: ONE,       b: 163'd2,    c: INV_X,    lat: 3};
    v[2] = '{a: 163'd32,   b: 163'd2,    c: 163'd16,  lat: 3};
    v[3] = '{a: POLY,      b: 163'd2,    c: X162,     lat: 3};
    v[4] = '{a: X162,      b: X162,      c: ONE,      lat: 164};
    v[5] = '{a: 163'd6,    b: 163'd3,    c: 163'd2,   lat: 0};
    v[6] = '{a: '0,        b: 163'd5,    c: '0,       lat: 0};
    v[7] = '{a: X162,      b: ONE,       c: X162,     lat: 2};
    for (int k = 0; k < 8; k++) begin
      run_op(v[k].a, v[k].b, c, e, lat);
      n_cmp++; if (c !== v[k].c) begin n_bad++; $display("FAIL dir%0d_c: got %h want %h", k, c, v[k].c); end
      n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL dir%0d_err: got %b want 0", k, e); end
      if (v[k].lat != 0) begin
        n_cmp++; if (lat != v[k].lat) begin n_bad++; $display("FAIL dir%0d_lat: got %0d want %0d", k, lat, v[k].lat); end
      end else begin
        n_cmp++; if (lat > MAXCYC + 2) begin n_bad++; $display("FAIL dir%0d_lat: got %0d want <= %0d", k, lat, MAXCYC + 2); end
      end
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL dir%0d_pulse: done %b want 0", k, bus.done); end
      n_cmp++; if (bus.c !== v[k].c) begin n_bad++; $display("FAIL dir%0d_hold: got %h want %h", k, bus.c, v[k].c); end
    end
  endtask

  task automatic test_random_model();
    logic [M-1:0] ra, rb, c;
    logic         e;
    int           lat;
    for (int k = 0; k < 16; k++) begin
      rb = rand163();
      ra = (k < 3) ? rb : rand163();
      run_op(ra, rb, c, e, lat);
      n_cmp++; if (gf_mul(c, rb) !== ra) begin n_bad++; $display("FAIL rnd%0d_prod: c*b %h want %h", k, gf_mul(c, rb), ra); end
      n_cmp++; if (lat > MAXCYC + 2) begin n_bad++; $display("FAIL rnd%0d_lat: got %0d want <= %0d", k, lat, MAXCYC + 2); end
      if (k < 3) begin
        n_cmp++; if (c !== ONE) begin n_bad++; $display("FAIL rnd%0d_self: got %h want 1", k, c); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_held_start();
    logic [M-1:0] c_prev;
    int           dones    = 0;
    int           done_lat = 0;
    bit           seen     = 1'b0;
    c_prev    = bus.c;
    bus.start = 1'b1;
    bus.a     = X162;
    bus.b     = X162;
    for (int lat = 1; lat <= 220; lat++) begin
      @(negedge clk);
      if (bus.done) begin dones++; done_lat = lat; seen = 1'b1; end
      if (lat == 100) begin
        n_cmp++; if (bus.c !== c_prev) begin n_bad++; $display("FAIL held_c_busy: got %h want %h", bus.c, c_prev); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL held_busy: got %b want 1", bus.busy); end
      end
      if (lat == 80) begin bus.a = 163'd2; bus.b = ONE; end
      bus.start = !seen && ((lat < 60) || (lat >= 80 && lat < 100) || (lat >= 150));
    end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL held_dones: got %0d want 1", dones); end
    n_cmp++; if (done_lat != 164) begin n_bad++; $display("FAIL held_lat: got %0d want 164", done_lat); end
    n_cmp++; if (bus.c !== ONE) begin n_bad++; $display("FAIL held_c: got %h want 1", bus.c); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL held_idle: busy %b want 0", bus.busy); end
  endtask

  task automatic test_zero_divisor();
    logic [M-1:0] c;
    logic         e;
    int           lat;
    run_op(163'd7, '0, c, e, lat);
`ifdef GF163_DIV_ZCHK_EN
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL zero_lat: got %0d want 1", lat); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL zero_err: got %b want 1", e); end
`else
    n_cmp++; if (lat != MAXCYC + 2) begin n_bad++; $display("FAIL zero_lat: got %0d want %0d", lat, MAXCYC + 2); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL zero_err: got %b want 0", e); end
`endif
    n_cmp++; if (c !== '0) begin n_bad++; $display("FAIL zero_c: got %h want 0", c); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [M-1:0] c;
    logic         e;
    int           lat;
    run_op(163'd32, 163'd2, c, e, lat);
    n_cmp++; if (c !== 163'd16) begin n_bad++; $display("FAIL b2b0_c: got %h want 10", c); end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy: got %b want 0", bus.busy); end
    run_op(POLY, 163'd2, c, e, lat);
    n_cmp++; if (c !== X162) begin n_bad++; $display("FAIL b2b1_c: got %h want %h", c, X162); end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL b2b1_lat: got %0d want 3", lat); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL b2b1_err: got %b want 0", e); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [M-1:0] c;
    logic         e;
    int           lat;
    int           dones = 0;
    bus.a     = ONE;
    bus.b     = X162;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL abort_pre_busy: got %b want 1", bus.busy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.c !== '0) begin n_bad++; $display("FAIL abort_c: got %h want 0", bus.c); end
    repeat (200) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL abort_done: got %0d want 0", dones); end
    run_op(POLY, 163'd2, c, e, lat);
    n_cmp++; if (c !== X162) begin n_bad++; $display("FAIL after_abort_c: got %h want %h", c, X162); end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL after_abort_lat: got %0d want 3", lat); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_model();
    test_held_start();
    test_zero_divisor();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
